// File: rtl/blimp_test_mem_responder.sv
// Test memory responder: tagged val/rdy requests in, in-order tagged responses out.
// Optional bounds checking is enabled by defining BLIMP_TEST_MEM_BOUNDS_CHECK_EN.
module blimp_test_mem_responder #(
   parameter int p_opaq_bits       = 8,
   parameter int p_num_words       = 256,
   parameter int p_send_intv_delay = 1,
   parameter int p_recv_intv_delay = 1,
   parameter int p_fifo_depth      = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_val,
   output logic                   req_rdy,
   input  logic                   req_op,
   input  logic [p_opaq_bits-1:0] req_opaque,
   input  logic [31:0]            req_addr,
   input  logic [31:0]            req_wdata,
   input  logic [3:0]             req_strb,
   output logic                   resp_val,
   input  logic                   resp_rdy,
   output logic                   resp_op,
   output logic [p_opaq_bits-1:0] resp_opaque,
   output logic [31:0]            resp_addr,
   output logic [31:0]            resp_data,
   input  logic                   init_en,
   input  logic [31:0]            init_addr,
   input  logic [31:0]            init_data,
   output logic                   err
);

   localparam int IW = $clog2(p_num_words);
   localparam int PW = $clog2(p_fifo_depth);
   localparam int CW = PW + 1;
   localparam int RW = (p_recv_intv_delay > 1) ? $clog2(p_recv_intv_delay) : 1;
   localparam int SW = (p_send_intv_delay > 1) ? $clog2(p_send_intv_delay) : 1;

   typedef struct packed {
      logic                   op;
      logic [p_opaq_bits-1:0] opaque;
      logic [31:0]            addr;
      logic [31:0]            data;
   } entry_t;

   logic [31:0]   mem [p_num_words];
   entry_t        fifo_mem [p_fifo_depth];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [RW-1:0] recv_cnt_q, recv_cnt_d;
   logic [SW-1:0] send_cnt_q, send_cnt_d;

   logic          fifo_full;
   logic          fifo_empty;
   logic          req_fire;
   logic          resp_fire;
   logic          req_oob;
   logic          req_wr;
   logic [IW-1:0] req_idx;
   logic [IW-1:0] init_idx;
   logic [31:0]   rd_data;
   logic [31:0]   wmask;
   logic [31:0]   wr_base;
   logic [31:0]   wr_word;
   entry_t        new_entry;
   entry_t        head;
   logic          unused_bits;

   assign unused_bits = ^{req_addr[1:0], req_addr[31:2+IW],
                          init_addr[1:0], init_addr[31:2+IW]};

   assign fifo_full  = (count_q == CW'(p_fifo_depth));
   assign fifo_empty = (count_q == '0);

   assign req_rdy   = !rst && (recv_cnt_q == '0) && !fifo_full;
   assign resp_val  = !fifo_empty && (send_cnt_q == '0);
   assign req_fire  = req_val && req_rdy;
   assign resp_fire = resp_val && resp_rdy;

   assign req_idx  = req_addr[2 +: IW];
   assign init_idx = init_addr[2 +: IW];

`ifdef BLIMP_TEST_MEM_BOUNDS_CHECK_EN
   logic err_q, err_d;

   assign req_oob = (req_addr >= 32'(4 * p_num_words));
   assign rd_data = req_oob ? 32'hDEAD_BEEF : mem[req_idx];
   assign err     = err_q;

   // Sticky flag for any accepted out-of-range request
   always_comb begin
      err_d = err_q;
      if (req_fire && req_oob)
         err_d = 1'b1;
   end

   // Error flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end
`else
   assign req_oob = 1'b0;
   assign rd_data = mem[req_idx];
   assign err     = 1'b0;
`endif

   assign req_wr = req_fire && req_op && !req_oob;

   assign wmask = {{8{req_strb[3]}}, {8{req_strb[2]}},
                   {8{req_strb[1]}}, {8{req_strb[0]}}};

   // Same-word backdoor write supplies the untouched bytes
   assign wr_base = (init_en && (init_idx == req_idx)) ? init_data
                                                       : mem[req_idx];
   assign wr_word = (wr_base & ~wmask) | (req_wdata & wmask);

   assign new_entry = '{op:     req_op,
                        opaque: req_opaque,
                        addr:   req_addr,
                        data:   req_op ? 32'h0 : rd_data};

   assign head = fifo_mem[rd_ptr_q];

   // Payload forced to zero when no response is offered
   assign resp_op     = resp_val ? head.op     : 1'b0;
   assign resp_opaque = resp_val ? head.opaque : '0;
   assign resp_addr   = resp_val ? head.addr   : 32'h0;
   assign resp_data   = resp_val ? head.data   : 32'h0;

   // Next-state for FIFO pointers, occupancy and interval counters
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      recv_cnt_d = recv_cnt_q;
      send_cnt_d = send_cnt_q;

      if (req_fire)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (resp_fire)
         rd_ptr_d = rd_ptr_q + 1'b1;

      if (req_fire && !resp_fire)
         count_d = count_q + 1'b1;
      else if (!req_fire && resp_fire)
         count_d = count_q - 1'b1;

      if (req_fire)
         recv_cnt_d = RW'(p_recv_intv_delay - 1);
      else if (recv_cnt_q != '0)
         recv_cnt_d = recv_cnt_q - 1'b1;

      if (resp_fire)
         send_cnt_d = SW'(p_send_intv_delay - 1);
      else if (send_cnt_q != '0)
         send_cnt_d = send_cnt_q - 1'b1;
   end

   // Control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         recv_cnt_q <= '0;
         send_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         recv_cnt_q <= recv_cnt_d;
         send_cnt_q <= send_cnt_d;
      end
   end

   // Response FIFO storage
   always_ff @(posedge clk) begin
      if (req_fire)
         fifo_mem[wr_ptr_q] <= new_entry;
   end

   // Memory array: backdoor word write, then request byte write
   always_ff @(posedge clk) begin
      if (init_en)
         mem[init_idx] <= init_data;
      if (req_wr)
         mem[req_idx] <= wr_word;
   end

endmodule
